// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control unit and its M-extension sequencer.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_BLT  = 4'b1010;
  localparam logic [3:0] OP_BGE  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;
  localparam logic [3:0] OP_BLTU = 4'b1110;
  localparam logic [3:0] OP_BGEU = 4'b1111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;

  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MD  = 7'b0000001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decode plus M-extension detection.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int MD_EN = 1
) (
  input  logic [1:0] i_alu_op,
  input  logic       i_rtype,
  input  logic [6:0] i_funct7,
  input  logic [2:0] i_funct3,
  output logic [3:0] o_operation,
  output logic       o_is_md
);

  logic w_alt;
  assign w_alt = (i_funct7 == F7_ALT);

  always_comb begin
    o_operation = OP_ADD;
    case (i_alu_op)
      ALUOP_BR: begin
        case (i_funct3)
          3'b001:  o_operation = OP_BNE;
          3'b100:  o_operation = OP_BLT;
          3'b101:  o_operation = OP_BGE;
          3'b110:  o_operation = OP_BLTU;
          3'b111:  o_operation = OP_BGEU;
          default: o_operation = OP_BEQ;
        endcase
      end
      ALUOP_RI: begin
        case (i_funct3)
          // ADDI reuses the funct7 field as immediate bits, so SUB needs RType
          3'b000:  o_operation = (i_rtype && w_alt) ? OP_SUB : OP_ADD;
          3'b001:  o_operation = OP_SLL;
          3'b010:  o_operation = OP_SLT;
          3'b011:  o_operation = OP_SLTU;
          3'b100:  o_operation = OP_XOR;
          3'b101:  o_operation = w_alt ? OP_SRA : OP_SRL;
          3'b110:  o_operation = OP_OR;
          default: o_operation = OP_AND;
        endcase
      end
      default: o_operation = OP_ADD;
    endcase
  end

  assign o_is_md = (MD_EN != 0) && (i_alu_op == ALUOP_RI) && i_rtype && (i_funct7 == F7_MD);

endmodule

// File: rtl/alu_ctrl_md.sv
// ALU control with a multi-cycle multiply/divide sequencer (radix-2 shift-add,
// restoring division) that stalls the pipeline while it iterates.
module alu_ctrl_md
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ALUOp,
  input  logic            RType,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            in_valid,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            in_ready,
  output logic [3:0]      Operation,
  output logic            is_md,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] md_result
);

  localparam int CW = $clog2(XLEN);

  md_state_e r_state, w_next;

  logic [XLEN-1:0] r_hi, r_lo, r_b, r_md_result;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic            r_neg;

  logic w_is_md, w_accept, w_last;

  alu_op_decode #(.MD_EN(MD_EN)) u_dec (
    .i_alu_op    (ALUOp),
    .i_rtype     (RType),
    .i_funct7    (Funct7),
    .i_funct3    (Funct3),
    .o_operation (Operation),
    .o_is_md     (w_is_md)
  );

  assign w_accept = (r_state == ST_IDLE) && in_valid && w_is_md;
  assign w_last   = (r_cnt == CW'(XLEN - 1));

  // Operand preparation at acceptance: magnitudes plus result sign
  logic            w_s1_signed, w_s2_signed, w_s1_neg, w_s2_neg, w_res_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_special_val;

  assign w_s1_signed = (Funct3 != MD_MULHU) && (Funct3 != MD_DIVU) && (Funct3 != MD_REMU);
  assign w_s2_signed = w_s1_signed && (Funct3 != MD_MULHSU);
  assign w_s1_neg    = w_s1_signed && rs1[XLEN-1];
  assign w_s2_neg    = w_s2_signed && rs2[XLEN-1];
  assign w_a_mag     = w_s1_neg ? -rs1 : rs1;
  assign w_b_mag     = w_s2_neg ? -rs2 : rs2;
  assign w_res_neg   = (Funct3 == MD_REM) ? w_s1_neg : (w_s1_neg ^ w_s2_neg);

  assign w_div0    = Funct3[2] && (rs2 == '0);
  assign w_ovf     = Funct3[2] && !Funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign w_special = w_div0 || w_ovf;

  always_comb begin
    w_special_val = '0;
    if (w_div0)
      w_special_val = Funct3[1] ? rs1 : '1;
    else
      w_special_val = Funct3[1] ? '0 : rs1;
  end

  // One iteration step; r_hi/r_lo are {acc, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]   w_sum, w_sh;
  logic [XLEN+1:0] w_tr;
  logic [XLEN-1:0] w_hi_nxt, w_lo_nxt;

  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_sh  = {r_hi, r_lo[XLEN-1]};
  assign w_tr  = {1'b0, w_sh} - {2'b00, r_b};

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_state == ST_MUL) begin
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end else if (r_state == ST_DIV) begin
      w_hi_nxt = w_tr[XLEN+1] ? w_sh[XLEN-1:0] : w_tr[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], ~w_tr[XLEN+1]};
    end
  end

  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_div_pick, w_div_s, w_final;

  assign w_prod     = {w_hi_nxt, w_lo_nxt};
  assign w_prod_s   = r_neg ? -w_prod : w_prod;
  assign w_div_pick = r_f3[1] ? w_hi_nxt : w_lo_nxt;
  assign w_div_s    = r_neg ? -w_div_pick : w_div_pick;

  always_comb begin
    w_final = w_div_s;
    if (!r_f3[2])
      w_final = (r_f3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_special ? ST_DONE : (Funct3[2] ? ST_DIV : ST_MUL);
      ST_MUL,
      ST_DIV:  if (w_last) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    stall     = in_valid && w_is_md && (r_state != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_f3        <= '0;
      r_neg       <= 1'b0;
      r_md_result <= '0;
    end else if (w_accept) begin
      r_f3  <= Funct3;
      r_neg <= w_res_neg;
      r_cnt <= '0;
      r_hi  <= '0;
      if (w_special) begin
        r_md_result <= w_special_val;
      end else if (Funct3[2]) begin
        r_lo <= w_a_mag;
        r_b  <= w_b_mag;
      end else begin
        r_lo <= w_b_mag;
        r_b  <= w_a_mag;
      end
    end else if ((r_state == ST_MUL) || (r_state == ST_DIV)) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_md_result <= w_final;
    end
  end

  assign is_md     = w_is_md;
  assign md_result = (MD_EN != 0) ? r_md_result : '0;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md with a cycle-level reference model.
module tb_alu_ctrl_md;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ALUOp;
  logic        RType;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic        in_valid;
  logic [31:0] rs1, rs2;
  logic        in_ready, is_md, stall, out_valid;
  logic [3:0]  Operation;
  logic [31:0] md_result;

  int n_chk = 0;
  int n_fail = 0;

  alu_ctrl_md #(.XLEN(32), .MD_EN(1)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .RType(RType), .Funct7(Funct7),
    .Funct3(Funct3), .in_valid(in_valid), .rs1(rs1), .rs2(rs2),
    .in_ready(in_ready), .Operation(Operation), .is_md(is_md), .stall(stall),
    .out_valid(out_valid), .md_result(md_result)
  );

  always #5 clk = ~clk;

  // model state
  bit          armed = 0;
  bit          m_busy = 0, m_done = 0;
  int          m_left = 0;
  logic [31:0] m_pend = '0, m_hold = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ref_is_md(input logic [1:0] op, input logic rt, input logic [6:0] f7);
    return (op == 2'b10) && rt && (f7 == 7'b0000001);
  endfunction

  function automatic logic [3:0] ref_op(input logic [1:0] op, input logic rt,
                                        input logic [6:0] f7, input logic [2:0] f3);
    if (op == 2'b01) begin
      case (f3)
        3'd1: return 4'h9;
        3'd4: return 4'hA;
        3'd5: return 4'hB;
        3'd6: return 4'hE;
        3'd7: return 4'hF;
        default: return 4'h8;
      endcase
    end
    if (op != 2'b10) return 4'h2;
    case (f3)
      3'd0: return (rt && f7 == 7'h20) ? 4'h3 : 4'h2;
      3'd1: return 4'h4;
      3'd2: return 4'hC;
      3'd3: return 4'hD;
      3'd4: return 4'h6;
      3'd5: return (f7 == 7'h20) ? 4'h7 : 4'h5;
      3'd6: return 4'h1;
      default: return 4'h0;
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    longint la, lb;
    sa = $signed(a);
    sb = $signed(b);
    la = longint'(sa);
    case (f3)
      3'd0, 3'd1: begin lb = longint'(sb); p = la * lb; end
      3'd2: begin lb = longint'({32'h0, b}); p = la * lb; end
      3'd3: p = {32'h0, a} * {32'h0, b};
      default: p = '0;
    endcase
    case (f3)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return (b == 0) ? 32'hFFFFFFFF : (ref_special(f3, a, b) ? a : 32'(sa / sb));
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: return (b == 0) ? a : (ref_special(f3, a, b) ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic model_step();
    if (reset) begin
      m_busy = 0; m_done = 0; m_hold = '0; armed = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_done = 1; m_hold = m_pend; end
    end else if (in_valid && ref_is_md(ALUOp, RType, Funct7)) begin
      m_pend = ref_md(Funct3, rs1, rs2);
      if (ref_special(Funct3, rs1, rs2)) begin m_done = 1; m_hold = m_pend; end
      else begin m_busy = 1; m_left = 32; end
    end
  endtask

  task automatic compare();
    logic md;
    if (!armed) return;
    md = ref_is_md(ALUOp, RType, Funct7);
    chk("in_ready", {31'b0, in_ready}, {31'b0, !m_busy && !m_done});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_done});
    chk("stall", {31'b0, stall}, {31'b0, in_valid && md && !m_done});
    chk("is_md", {31'b0, is_md}, {31'b0, md});
    chk("md_result", md_result, m_hold);
    if (!md) chk("operation", {28'b0, Operation}, {28'b0, ref_op(ALUOp, RType, Funct7, Funct3)});
  endtask

  // compare at negedge, advance model at posedge, drive inputs at posedge+1
  task automatic tick(output logic s, output logic ov, output logic [31:0] res);
    @(negedge clk);
    compare();
    s = stall; ov = out_valid; res = md_result;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_md(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    logic s, ov;
    logic [31:0] res, got_res;
    int cyc, stalls;
    bit got;
    in_valid = 1; ALUOp = 2'b10; RType = 1; Funct7 = 7'b0000001; Funct3 = f3; rs1 = a; rs2 = b;
    cyc = 0; stalls = 0; got = 0; got_res = '0;
    while (!got && cyc < 100) begin
      tick(s, ov, res);
      if (s) stalls++;
      if (ov) begin
        got = 1; got_res = res;
      end else begin
        cyc++;
        if (cyc == 5) begin rs1 = $urandom; rs2 = $urandom; end
      end
    end
    in_valid = 0;
    chk({name, "_done"}, {31'b0, got}, 32'd1);
    chk({name, "_latency"}, cyc, lat);
    chk({name, "_stall_cycles"}, stalls, lat);
    chk({name, "_result"}, got_res, exp);
  endtask

  localparam logic [16:0] DEC [16] = '{
    {2'b10, 1'b0, 7'h20, 3'd0, 4'h2}, {2'b10, 1'b1, 7'h20, 3'd0, 4'h3},
    {2'b01, 1'b0, 7'h00, 3'd5, 4'hB}, {2'b10, 1'b1, 7'h00, 3'd4, 4'h6},
    {2'b10, 1'b1, 7'h00, 3'd3, 4'hD}, {2'b00, 1'b0, 7'h00, 3'd7, 4'h2},
    {2'b11, 1'b1, 7'h20, 3'd0, 4'h2}, {2'b01, 1'b0, 7'h00, 3'd2, 4'h8},
    {2'b01, 1'b0, 7'h00, 3'd6, 4'hE}, {2'b10, 1'b0, 7'h20, 3'd5, 4'h7},
    {2'b10, 1'b1, 7'h00, 3'd5, 4'h5}, {2'b10, 1'b1, 7'h00, 3'd1, 4'h4},
    {2'b10, 1'b1, 7'h00, 3'd7, 4'h0}, {2'b10, 1'b0, 7'h00, 3'd6, 4'h1},
    {2'b10, 1'b1, 7'h00, 3'd2, 4'hC}, {2'b01, 1'b1, 7'h00, 3'd1, 4'h9}
  };

  localparam logic [2:0]  MF3 [16] = '{3'd1, 3'd0, 3'd4, 3'd6, 3'd5, 3'd4, 3'd5, 3'd7,
                                       3'd3, 3'd2, 3'd6, 3'd4, 3'd7, 3'd6, 3'd4, 3'd0};
  localparam logic [31:0] MA  [16] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                       32'h80000000, 32'h80000000, 32'h5, 32'h5,
                                       32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h64,
                                       32'h64, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000};
  localparam logic [31:0] MB  [16] = '{32'h2, 32'h2, 32'h2, 32'h2,
                                       32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                                       32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                       32'h7, 32'h0, 32'h0, 32'h80000000};
  localparam logic [31:0] MX  [16] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                       32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h5,
                                       32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFF2,
                                       32'h2, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h0};
  localparam int          ML  [16] = '{33, 33, 33, 33, 33, 1, 1, 1, 33, 33, 1, 33, 33, 1, 1, 33};

  initial begin
    logic s, ov;
    logic [31:0] res;
    logic [16:0] e;
    reset = 1; ALUOp = '0; RType = 0; Funct7 = '0; Funct3 = '0; in_valid = 0; rs1 = '0; rs2 = '0;
    repeat (3) tick(s, ov, res);
    reset = 0;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_md_result", md_result, 32'd0);

    for (int i = 0; i < 16; i++) begin
      e = DEC[i];
      ALUOp = e[16:15]; RType = e[14]; Funct7 = e[13:7]; Funct3 = e[6:4]; in_valid = i[0];
      #1;
      chk($sformatf("decode_%0d", i), {28'b0, Operation}, {28'b0, e[3:0]});
      tick(s, ov, res);
    end
    in_valid = 0;
    tick(s, ov, res);

    for (int i = 0; i < 16; i++) begin
      run_md($sformatf("md_%0d", i), MF3[i], MA[i], MB[i], MX[i], ML[i]);
      tick(s, ov, res);
    end

    // abort a multiply ten cycles in, then let the held instruction reissue
    in_valid = 1; ALUOp = 2'b10; RType = 1; Funct7 = 7'b0000001; Funct3 = 3'd0;
    rs1 = 32'h00010003; rs2 = 32'h00000100;
    repeat (11) tick(s, ov, res);
    reset = 1;
    repeat (2) tick(s, ov, res);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_md_result", md_result, 32'd0);
    reset = 0;
    run_md("reissue", 3'd0, 32'h00010003, 32'h00000100, 32'h01000300, 33);
    repeat (2) tick(s, ov, res);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_md.md
ALU_CTRL_MD -- requirements
Module: alu_ctrl_md

Interface
REQ-001 Parameter XLEN, default 32, operand/result width (>=8, power of 2).
REQ-002 Parameter MD_EN, default 1, enables M-extension sequencer; 0 SHALL tie md outputs to 0 and stall to 0.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Ports: clk in 1 clock; reset in 1 sync active-high reset; ALUOp in 2 (00 mem, 01 branch, 10 R/I-type); RType in 1 (1 = R-type, 0 = I-type); Funct7 in 7; Funct3 in 3; in_valid in 1 instruction present in EX; rs1 in XLEN; rs2 in XLEN; in_ready out 1; Operation out 4; is_md out 1; stall out 1; out_valid out 1; md_result out XLEN.

Function
REQ-005 Operation SHALL be combinational: AND 0000, OR 0001, ADD 0010, SUB 0011, SLL 0100, SRL 0101, XOR 0110, SRA 0111, SLT 1100, SLTU 1101.
REQ-006 ALUOp 00 SHALL give ADD; ALUOp 11 SHALL give ADD.
REQ-007 ALUOp 01 SHALL map Funct3 000/001/100/101/110/111 to BEQ 1000, BNE 1001, BLT 1010, BGE 1011, BLTU 1110, BGEU 1111; Funct3 010/011 -> 1000.
REQ-008 Funct7 SHALL select SUB only when RType=1, and SRA only for Funct3 101 (R- or I-type); ADDI with Funct7 0100000 SHALL give ADD.
REQ-009 is_md SHALL be 1 iff MD_EN, ALUOp=10, RType=1, Funct7=0000001; Funct3 000-011 = MUL/MULH/MULHSU/MULHU, 100-111 = DIV/DIVU/REM/REMU; Operation is don't-care when is_md.
REQ-010 FSM states IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-011 IDLE->MUL/DIV on in_valid & is_md at a clock edge; operands and Funct3 latched; signed operands converted to magnitudes with result-sign flags.
REQ-012 MUL: radix-2 shift-add, exactly XLEN iteration cycles producing 2*XLEN product; DIV: restoring, exactly XLEN iteration cycles; then DONE.
REQ-013 DONE SHALL last exactly one cycle: out_valid=1, md_result valid (sign-corrected, MUL low half, MULH*/ high half, DIV quotient, REM remainder), then IDLE.
REQ-014 Latency: out_valid SHALL assert XLEN+1 cycles after the accepting edge for normal ops.
REQ-015 Divide by zero: quotient all-ones, remainder = rs1; signed overflow (rs1 = most-negative, rs2 = -1): quotient = rs1, remainder 0; both SHALL skip iteration and enter DONE on the next edge (out_valid 1 cycle after acceptance).
REQ-016 stall SHALL equal in_valid & is_md & (state != DONE); stall SHALL be 0 in DONE so the pipeline advances with md_result.
REQ-017 md_result SHALL hold its last value outside DONE; in_valid/operand changes outside IDLE SHALL be ignored.
REQ-018 Non-md instructions SHALL never assert stall and never change FSM state.

Reset
REQ-019 On reset at a clock edge: state IDLE, out_valid 0, md_result 0, internal accumulators 0; in_ready 1 the cycle after.
REQ-020 Reset mid-operation SHALL abort without producing out_valid; a pending instruction SHALL be re-accepted only after reset deasserts.

Structure
REQ-021 Package alu_pkg SHALL hold the 4-bit Operation codes, ALUOp codes, M-extension Funct3 codes and the FSM state enum.
REQ-022 Combinational decode (REQ-005..009) SHALL be sub-module alu_op_decode, instantiated once; sequencer and datapath live in alu_ctrl_md.

Verification
REQ-023 ALUOp=10, RType=0, Funct3=000, Funct7=0100000 -> Operation 0010; RType=1 -> 0011.
REQ-024 ALUOp=01, Funct3=101 -> 1011; Funct3=100, ALUOp=10 -> XOR 0110; Funct3=011 -> SLTU 1101.
REQ-025 XLEN=32, MULH rs1=0xFFFFFFFF, rs2=0x00000002 -> stall high 33 cycles, out_valid at cycle 33, md_result 0xFFFFFFFF; MUL same operands -> 0xFFFFFFFE.
REQ-026 DIV rs1=-7, rs2=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0x80000000/0xFFFFFFFF -> 0; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 cycle.
REQ-027 DIVU rs1=5, rs2=0 -> 0xFFFFFFFF; REMU -> 5; out_valid 1 cycle after acceptance.
REQ-028 Reset asserted 10 cycles into MUL -> no out_valid, state IDLE, md_result 0; reissue completes normally with correct result.
